// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, state encoding and saturation limits for the IFFT output serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

    localparam int N           = 16;              // points per frame (power of 2)
    localparam int IN_W        = 64;              // signed input sample width
    localparam int OUT_W       = 32;              // signed, saturated output width
    localparam int SCALE_SHIFT = 4;               // log2(N): the 1/N scaling
    localparam int IDX_W       = $clog2(N);

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

endpackage

// File: rtl/fft_round_sat.sv
// fft_round_sat: one lane of 1/N scaling, round-to-nearest (ties toward +inf), saturate to OUT_W.
// Latency: combinational.
// Backpressure: none (pure function of din).
// Ports: din [IN_W] signed input, dout [OUT_W] scaled result, sat = result was clipped.
module fft_round_sat
    import fft_pkg::*;
(
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);

    // Half an output LSB, expressed at input scale.
    localparam logic [IN_W:0] HALF = {{(IN_W+1-SCALE_SHIFT){1'b0}}, 1'b1, {(SCALE_SHIFT-1){1'b0}}};

    logic signed [IN_W:0]        ext;
    logic signed [IN_W:0]        sum;
    logic signed [IN_W:0]        shr;
    logic [IN_W-OUT_W+1:0]       hi;

    always_comb begin
        // One guard bit so adding HALF to the most positive input cannot wrap.
        ext  = {din[IN_W-1], din};
        sum  = ext + HALF;
        shr  = sum >>> SCALE_SHIFT;
        // Fits in OUT_W only if every bit from the output sign bit upward agrees.
        hi   = shr[IN_W:OUT_W-1];
        sat  = !((&hi) || !(|hi));
        dout = sat ? (shr[IN_W] ? SAT_MIN : SAT_MAX) : shr[OUT_W-1:0];
    end

endmodule

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures a parallel N-point complex frame, scales/rounds/saturates it, streams one sample per beat.
// Latency: frame captured at edge k, sample 0 valid in the cycle after k; N beats per frame without stalls.
// Backpressure: out_ready low holds all outputs; in_ready also opens on an accepted last beat so frames run back to back.
// Ports: clk/rst_n (sync, active low); in_valid/in_ready + in_real/in_im (N lanes of IN_W);
//        out_valid/out_ready + out_real/out_im/out_idx/out_last; busy while a frame is held.
// Optional: define FFT_OUT_SER_SAT_FLAG_EN to add out_sat (per-sample clip flag) and sat_sticky.
module fft_out_serializer
    import fft_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0][IN_W-1:0]    in_real,
    input  logic [N-1:0][IN_W-1:0]    in_im,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_real,
    output logic [OUT_W-1:0]          out_im,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_last,
    output logic                      busy
`ifdef FFT_OUT_SER_SAT_FLAG_EN
    ,
    output logic                      out_sat,
    output logic                      sat_sticky
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

    ser_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             at_last;
    logic             cap;

    logic [OUT_W-1:0] sc_re  [N];
    logic [OUT_W-1:0] sc_im  [N];
    logic [OUT_W-1:0] buf_re [N];
    logic [OUT_W-1:0] buf_im [N];
    logic [N-1:0]     sat_re;
    logic [N-1:0]     sat_im;

    // Scaling happens in front of the buffer so the stored frame is already output-ready.
    for (genvar g = 0; g < N; g++) begin : g_lane
        fft_round_sat u_rs_re (.din(in_real[g]), .dout(sc_re[g]), .sat(sat_re[g]));
        fft_round_sat u_rs_im (.din(in_im[g]),   .dout(sc_im[g]), .sat(sat_im[g]));
    end

    always_comb begin
        at_last  = (state_q == STREAM) && (idx_q == LAST_IDX);
        // Only combinational input-to-output path: out_ready on the last beat opens in_ready.
        in_ready = (state_q == IDLE) || (at_last && out_ready);
        cap      = in_valid && in_ready;
        state_d  = state_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (cap) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = cap ? STREAM : IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Buffer contents are don't-care after reset; the outputs are gated instead.
    always_ff @(posedge clk) begin
        if (cap) begin
            for (int i = 0; i < N; i++) begin
                buf_re[i] <= sc_re[i];
                buf_im[i] <= sc_im[i];
            end
        end
    end

    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_last  = at_last;
    assign out_idx   = idx_q;
    assign out_real  = (state_q == STREAM) ? buf_re[idx_q] : '0;
    assign out_im    = (state_q == STREAM) ? buf_im[idx_q] : '0;

`ifdef FFT_OUT_SER_SAT_FLAG_EN
    logic [N-1:0] sat_buf;

    always_ff @(posedge clk) begin
        if (cap) begin
            sat_buf <= sat_re | sat_im;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_sticky <= 1'b0;
        end else if (cap && (|(sat_re | sat_im))) begin
            sat_sticky <= 1'b1;
        end
    end

    assign out_sat = (state_q == STREAM) && sat_buf[idx_q];
`else
    logic unused_sat;
    assign unused_sat = ^{sat_re, sat_im};
`endif

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer: randomized and directed frames checked against a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: out_ready driven directly, held, or randomized.
module tb_fft_out_serializer;
    import fft_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0][IN_W-1:0] in_real;
    logic [N-1:0][IN_W-1:0] in_im;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_real;
    logic [OUT_W-1:0]       out_im;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;
    logic                   busy;
`ifdef FFT_OUT_SER_SAT_FLAG_EN
    logic                   out_sat;
    logic                   sat_sticky;
`endif

    fft_out_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
`ifdef FFT_OUT_SER_SAT_FLAG_EN
        ,
        .out_sat   (out_sat),
        .sat_sticky(sat_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        int          idx;
        bit          last;
        bit          sat;
    } beat_t;

    beat_t q[$];
    bit    exp_sticky = 0;
    bit    mon_rdy;

    // round(x / 16) with ties toward +inf, then clip to 32-bit signed range
    function automatic logic [31:0] ref_scale(input logic [63:0] x, output bit s);
        longint signed v;
        longint signed fl;
        v  = signed'(x);
        fl = v / 16;
        if ((v % 16 != 0) && (v < 0)) fl = fl - 1;
        if (v - fl * 16 >= 8) fl = fl + 1;
        s = 1'b0;
        if (fl > 64'sd2147483647) begin
            s = 1'b1;
            return 32'h7FFF_FFFF;
        end
        if (fl < -64'sd2147483648) begin
            s = 1'b1;
            return 32'h8000_0000;
        end
        return fl[31:0];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_sticky = 0;
        end else begin
            mon_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
            check("in_ready",  in_ready,  mon_rdy);
            check("out_valid", out_valid, q.size() != 0);
            check("busy",      busy,      q.size() != 0);
`ifdef FFT_OUT_SER_SAT_FLAG_EN
            check("sat_sticky", sat_sticky, exp_sticky);
`endif
            if (q.size() != 0) begin
                check("out_real", out_real, q[0].re);
                check("out_im",   out_im,   q[0].im);
                check("out_idx",  out_idx,  q[0].idx);
                check("out_last", out_last, q[0].last);
`ifdef FFT_OUT_SER_SAT_FLAG_EN
                check("out_sat",  out_sat,  q[0].sat);
`endif
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && mon_rdy) begin
                for (int i = 0; i < N; i++) begin
                    beat_t b;
                    bit    sr, si;
                    b.re   = ref_scale(in_real[i], sr);
                    b.im   = ref_scale(in_im[i], si);
                    b.idx  = i;
                    b.last = (i == N - 1);
                    b.sat  = sr | si;
                    if (b.sat) exp_sticky = 1;
                    q.push_back(b);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] fr_re [N];
    logic [63:0] fr_im [N];
    bit          rdy_rand = 0;

    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [63:0] rand_val();
        longint signed v;
        case ($urandom_range(0, 3))
            0:       v = signed'({$urandom(), $urandom()});
            1:       v = longint'($urandom_range(0, 4000)) - 2000;
            2:       v = (longint'($urandom_range(0, 400)) - 200) * 16 + 8;
            default: begin
                v = 64'sh7_FFFF_FFF0 + longint'($urandom_range(0, 47)) - 24;
                if ($urandom_range(0, 1) == 1) v = -v;
            end
        endcase
        return v;
    endfunction

    task automatic rand_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = rand_val();
            fr_im[i] = rand_val();
        end
    endtask

    task automatic send_frame();
        int waited = 0;
        for (int i = 0; i < N; i++) begin
            in_real[i] = fr_re[i];
            in_im[i]   = fr_im[i];
        end
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((out_valid || q.size() != 0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("drain_valid", out_valid, 0);
        check("drain_model", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int target);
        int k = 0;
        @(negedge clk);
        while (!(out_valid && out_ready && out_idx == target) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("wait_idx", out_idx, target);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_real   = '0;
        in_im     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last",  out_last,  0);
        check("rst_busy",      busy,      0);
        check("rst_out_idx",   out_idx,   0);
        check("rst_out_real",  out_real,  0);
        check("rst_out_im",    out_im,    0);
        check("rst_in_ready",  in_ready,  1);
        @(posedge clk);
        #1;

        // basic ramp: out_real = i, out_im = -i
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 64'(16 * i);
            fr_im[i] = 64'(-16 * i);
        end
        send_frame();
        wait_idle();

        // rounding ties and near-ties
        rand_frame();
        fr_re[0] = 64'd24;
        fr_re[1] = -64'sd24;
        fr_re[2] = 64'd8;
        fr_re[3] = -64'sd8;
        fr_re[4] = 64'd7;
        fr_im[0] = 64'd7;
        fr_im[1] = -64'sd9;
        send_frame();
        wait_idle();

        // saturation in both directions on lane 0
        for (int i = 0; i < N; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
        fr_re[0] = 64'h0000_0100_0000_0000;
        fr_im[0] = -64'sh0000_0100_0000_0000;
        send_frame();
        wait_idle();

        // backpressure: stall three cycles on sample 5
        rand_frame();
        send_frame();
        wait_idx(4);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();

        // back-to-back frames with in_valid held high
        rand_frame();
        send_frame();
        rand_frame();
        send_frame();
        wait_idle();

        // reset in the middle of a frame
        rand_frame();
        send_frame();
        wait_idx(6);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready",  in_ready,  1);
        check("mid_rst_out_idx",   out_idx,   0);
        check("mid_rst_out_real",  out_real,  0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 64'(16 * i + 3);
            fr_im[i] = 64'(-16 * i - 9);
        end
        send_frame();
        wait_idle();

        // random data with random backpressure, frames queued back to back
        rdy_rand = 1;
        for (int f = 0; f < 8; f++) begin
            rand_frame();
            send_frame();
        end
        rdy_rand = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
- Downstream of the conjugate/scale stage in the IFFT path.
- Captures one 16-point complex frame (parallel, 64-bit signed) and applies the final 1/N scaling with round-to-nearest and saturation.
- Streams the frame out one sample per cycle over a valid/ready handshake to the output sink.
- Double-registered: the next frame can be accepted on the last output beat, so back-to-back frames have no bubble.

Parameters:
- N, 16, points per frame (power of 2).
- IN_W, 64, input sample width (signed).
- OUT_W, 32, output sample width (signed, saturated).
- SCALE_SHIFT, 4, arithmetic right shift applied (log2 N).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  parallel frame present.
- in_ready  out  1  block can accept a frame this cycle.
- in_real  in  IN_W x N  real parts, index 0..N-1.
- in_im  in  IN_W x N  imaginary parts.
- out_valid  out  1  output sample valid.
- out_ready  in  1  sink accepts sample.
- out_real  out  OUT_W  scaled real sample.
- out_im  out  OUT_W  scaled imaginary sample.
- out_idx  out  log2(N)  index of current sample.
- out_last  out  1  high with out_valid on index N-1.
- busy  out  1  frame held (state STREAM).

Behaviour:
- Reset (rst_n low at clk edge):
  - state=IDLE; out_valid=0, out_last=0, busy=0, out_idx=0.
  - Frame buffer contents are don't-care, but out_real and out_im read 0.
  - A frame in flight is discarded with no partial completion.
- States:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) captures all 2N lanes into the buffer, sets idx=0, goes to STREAM.
  - STREAM: out_valid=1; out_real/out_im = buf[idx].
    - On out_valid & out_ready with idx<N-1: idx increments.
    - With idx==N-1: out_last=1 on that beat. If in_valid is also high, the new frame is captured on the same edge and the block stays in STREAM with idx=0. Otherwise it goes to IDLE.
- in_ready = (state==IDLE) | (state==STREAM & idx==N-1 & out_ready). This is combinational from out_ready, and is the only comb path from input to output.
- Latency: frame captured at edge k; sample 0 is visible with out_valid in the cycle after k. Streaming a frame with no backpressure takes N cycles.
- Backpressure: while out_valid & !out_ready, out_real, out_im, out_idx and out_last hold stable.
- Arithmetic (per lane, applied at capture):
  - Sign-extend to IN_W+1 bits.
  - Add 2^(SCALE_SHIFT-1).
  - Arithmetic shift right by SCALE_SHIFT. Ties round toward +infinity.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- in_valid while busy and not on the final accepted beat: ignored, not captured, in_ready=0.
- Simultaneous reset and handshake: reset wins.

Optional Feature:
- Macro: FFT_OUT_SER_SAT_FLAG_EN.
- Defined:
  - Adds output out_sat (1 bit), high with a sample if either lane of that sample saturated at capture.
  - Adds output sat_sticky (1 bit), set on any saturating capture and cleared only by reset.
  - Saturation flags are stored per buffer entry.
- Undefined: ports and flag storage are absent; saturation arithmetic is unchanged.

Decomposition:
- Package fft_pkg:
  - N, IN_W, OUT_W, SCALE_SHIFT defaults.
  - IDX_W = $clog2(N).
  - Enum ser_state_t {IDLE, STREAM}.
  - Saturation min/max constants.
- Sub-module fft_round_sat: one-lane scale, round and saturate, combinational. Ports are din (IN_W), dout (OUT_W) and sat (1). It is instantiated 2N times in front of the buffer.

Test Plan:
- Basic frame: in_real[i]=16*i, in_im[i]=-16*i, out_ready=1 → 16 consecutive beats, out_real=i, out_im=-i, out_idx=i, out_last only at i=15, then IDLE with in_ready=1.
- Rounding: inputs 24, -24, 8, -8, 7 → outputs 2, -1, 1, 0, 0.
- Saturation: in_real[0]=2^40, in_im[0]=-(2^40) → out_real=0x7FFFFFFF, out_im=0x80000000. With the macro defined, out_sat=1 on beat 0 and sat_sticky=1 thereafter.
- Backpressure: drop out_ready for 3 cycles at idx=5 → outputs hold sample 5 unchanged and idx does not advance. The frame still completes with 16 beats total.
- Back-to-back: in_valid held high with two distinct frames → the second frame is captured on the last beat of the first, and beat 0 of frame 2 follows beat 15 of frame 1 with no idle cycle.
- Reset mid-stream: rst_n low for 1 cycle at idx=7 → next cycle out_valid=0, in_ready=1, idx=0. The next frame streams from idx 0 correctly.
